spi_slave_mb: RTL and testbench

- Parametrised successor of the fixed 32-bit SPI slave, used as the external-master-facing port on the test boards.
- Supports 1..MAX_BYTES byte transactions and all four CPOL/CPHA modes.
- Internally synchronises SCLK/CS/MOSI to the system clock and adds a completion/abort handshake.
- Adds a configurable idle level for MISO.

---
 rtl/spi_slave_mb.sv | 180 ++++++++++++++++++
 tb/tb_spi_slave_mb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mb.sv
// SPI slave, 1..MAX_BYTES bytes per frame, all CPOL/CPHA modes, pins synchronised to clk.
// Optional LSB-first mode: define SPI_SLAVE_MB_LSB_FIRST_EN to add the lsb_first port.
//
//   state | meaning
//   IDLE  | CS high or waiting for a synced CS falling edge
//   SHIFT | frame in progress, shifting on synced SCLK edges
//   DONE  | all N bits received, waiting for CS to rise
module spi_slave_mb #(
    parameter int   MAX_BYTES = 4,
    parameter int   LEN_W     = 2,
    parameter logic MISO_IDLE = 1'bz
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MOSI,
    output logic                   MISO,
    input  logic                   SPI_SCLK,
    input  logic                   CS,
    input  logic [8*MAX_BYTES-1:0] tx_data,
    output logic [8*MAX_BYTES-1:0] rx_data,
    input  logic [LEN_W-1:0]       transaction_length,
    input  logic                   CPOL,
    input  logic                   CPHA,
`ifdef SPI_SLAVE_MB_LSB_FIRST_EN
    input  logic                   lsb_first,
`endif
    output logic                   busy,
    output logic                   rx_valid,
    output logic                   abort
);
    localparam int W     = 8*MAX_BYTES;
    localparam int CNT_W = $clog2(W+1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;

    logic [1:0] sclk_sr, cs_sr, mosi_sr;
    logic       sclk_d, cs_d;
    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic             cpol_q, cpha_q, lsb_q, lsb_in;
    logic [CNT_W-1:0] n_q, n_calc, cnt;
    logic [W-1:0]     tx_sr, tx_aligned, tx_load_sr, rx_sr, rx_sr_nx, rx_final;
    logic             tx_bit, tx_load_bit;
    logic             sample_edge, shift_edge;
    logic             start, do_sample, do_shift, finish, abort_nx;

`ifdef SPI_SLAVE_MB_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sr <= 2'b00;
            cs_sr   <= 2'b11;
            mosi_sr <= 2'b00;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b1;
        end else begin
            sclk_sr <= {sclk_sr[0], SPI_SCLK};
            cs_sr   <= {cs_sr[0], CS};
            mosi_sr <= {mosi_sr[0], MOSI};
            sclk_d  <= sclk_sr[1];
            cs_d    <= cs_sr[1];
        end
    end

    assign sclk_s    = sclk_sr[1];
    assign cs_s      = cs_sr[1];
    assign mosi_s    = mosi_sr[1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    assign sample_edge = (cpol_q ^ cpha_q) ? sclk_fall : sclk_rise;
    assign shift_edge  = (cpol_q ^ cpha_q) ? sclk_rise : sclk_fall;

    // Lengths beyond the port width saturate to the full word.
    always_comb begin
        if (transaction_length >= LEN_W'(MAX_BYTES-1))
            n_calc = CNT_W'(W);
        else
            n_calc = CNT_W'({transaction_length, 3'b000}) + CNT_W'(8);
    end

    assign tx_aligned  = tx_data << (CNT_W'(W) - n_calc);
    assign tx_load_bit = lsb_in ? tx_data[0] : tx_aligned[W-1];
    // With CPHA=0 the first bit is already on MISO, so the register starts one bit ahead.
    assign tx_load_sr  = lsb_in ? (CPHA ? tx_data : tx_data >> 1)
                                : (CPHA ? tx_aligned : tx_aligned << 1);

    assign rx_sr_nx = lsb_q ? {mosi_s, rx_sr[W-1:1]} : {rx_sr[W-2:0], mosi_s};
    assign rx_final = lsb_q ? (rx_sr_nx >> (CNT_W'(W) - n_q)) : rx_sr_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        finish    = 1'b0;
        abort_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    start    = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort_nx = 1'b1;
                    state_nx = IDLE;
                end else if (sample_edge) begin
                    do_sample = 1'b1;
                    if (cnt + CNT_W'(1) == n_q) begin
                        finish   = 1'b1;
                        state_nx = DONE;
                    end
                end else if (shift_edge) begin
                    do_shift = 1'b1;
                end
            end
            DONE: begin
                if (cs_rise) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            n_q      <= '0;
            cnt      <= '0;
            tx_sr    <= '0;
            tx_bit   <= 1'b0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            abort    <= 1'b0;
        end else begin
            rx_valid <= finish;
            abort    <= abort_nx;
            if (start) begin
                cpol_q <= CPOL;
                cpha_q <= CPHA;
                lsb_q  <= lsb_in;
                n_q    <= n_calc;
                cnt    <= '0;
                tx_sr  <= tx_load_sr;
                tx_bit <= tx_load_bit;
                rx_sr  <= '0;
            end
            if (do_shift) begin
                tx_bit <= lsb_q ? tx_sr[0] : tx_sr[W-1];
                tx_sr  <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
            end
            if (do_sample) begin
                rx_sr <= rx_sr_nx;
                cnt   <= cnt + CNT_W'(1);
            end
            if (finish) rx_data <= rx_final;
        end
    end

    assign MISO = cs_s ? MISO_IDLE : tx_bit;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_mb.sv
// Directed bench for spi_slave_mb: bit-banged SPI master plus an rx_data scoreboard.
module tb_spi_slave_mb;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        MOSI, MISO, SPI_SCLK, CS, CPOL, CPHA;
    logic [31:0] tx_data, rx_data;
    logic [1:0]  transaction_length;
    logic        busy, rx_valid, abort;

    int          n_cmp = 0;
    int          n_err = 0;
    int          rxv_cnt = 0;
    int          abort_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m;

    always #5 clk = ~clk;

    spi_slave_mb #(.MAX_BYTES(4), .LEN_W(2), .MISO_IDLE(1'b1)) dut (
        .clk(clk), .rst(rst), .MOSI(MOSI), .MISO(MISO), .SPI_SCLK(SPI_SCLK), .CS(CS),
        .tx_data(tx_data), .rx_data(rx_data), .transaction_length(transaction_length),
        .CPOL(CPOL), .CPHA(CPHA), .busy(busy), .rx_valid(rx_valid), .abort(abort)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Runs ncyc SCLK cycles of a frame whose MOSI word is nbits long; returns bits seen on MISO.
    task automatic spi_xfer(input bit cpol, input bit cpha, input int nbits, input int ncyc,
                            input logic [31:0] mosi_w, input bit raise_cs, input int toggle_at,
                            output logic [31:0] miso_w);
        logic b;
        miso_w = '0;
        SPI_SCLK = cpol;
        wait_clk(6);
        CS = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < ncyc; i++) begin
            if (i == toggle_at) begin
                tx_data = ~tx_data;
                CPOL    = ~CPOL;
            end
            b = 1'b0;
            if (i < nbits) b = mosi_w[nbits-1-i];
            if (!cpha) begin
                MOSI = b;
                SPI_SCLK = ~SPI_SCLK;
                miso_w = {miso_w[30:0], MISO};
                wait_clk(HALF);
                SPI_SCLK = ~SPI_SCLK;
                wait_clk(HALF);
            end else begin
                SPI_SCLK = ~SPI_SCLK;
                MOSI = b;
                wait_clk(HALF);
                SPI_SCLK = ~SPI_SCLK;
                miso_w = {miso_w[30:0], MISO};
                wait_clk(HALF);
            end
        end
        if (raise_cs) CS = 1'b1;
    endtask

    always @(negedge clk) begin
        if (abort === 1'b1) abort_cnt++;
        if (rx_valid === 1'b1) begin
            rxv_cnt++;
            if (exp_q.size() == 0) check("rx_valid_unexpected", rx_valid, 1'b0);
            else                   check("rx_data", rx_data, exp_q.pop_front());
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; CS = 1'b1; SPI_SCLK = 1'b0; MOSI = 1'b0;
        CPOL = 1'b0; CPHA = 1'b0; tx_data = '0; transaction_length = '0;
        wait_clk(5);
        check("reset_rx_data", rx_data, 32'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_abort", abort, 1'b0);
        check("reset_miso", MISO, 1'b1);
        rst = 1'b1;
        wait_clk(5);

        // mode 0, one byte
        CPOL = 0; CPHA = 0; transaction_length = 2'd0; tx_data = 32'h000000A5;
        exp_q.push_back(32'h0000003C); rxv_cnt = 0;
        spi_xfer(0, 0, 8, 8, 32'h3C, 1, -1, m);
        wait_clk(2);
        check("m0_busy_hold", busy, 1'b1);
        wait_clk(1);
        check("m0_busy_fall", busy, 1'b0);
        check("m0_miso_bits", m[7:0], 8'hA5);
        wait_clk(10);
        check("m0_rx_valid_cnt", rxv_cnt, 1);
        check("m0_miso_idle", MISO, 1'b1);

        // mode 3, four bytes
        CPOL = 1; CPHA = 1; transaction_length = 2'd3; tx_data = 32'hDEADBEEF;
        exp_q.push_back(32'h12345678); rxv_cnt = 0;
        spi_xfer(1, 1, 32, 32, 32'h12345678, 1, -1, m);
        wait_clk(10);
        check("m3_miso_word", m, 32'hDEADBEEF);
        check("m3_rx_valid_cnt", rxv_cnt, 1);

        // mode 1, two bytes
        CPOL = 0; CPHA = 1; transaction_length = 2'd1; tx_data = 32'h0000CAFE;
        exp_q.push_back(32'h0000BEEF); rxv_cnt = 0;
        spi_xfer(0, 1, 16, 16, 32'hBEEF, 1, -1, m);
        wait_clk(10);
        check("m1_miso_word", m[15:0], 16'hCAFE);
        check("m1_rx_valid_cnt", rxv_cnt, 1);

        // mode 2, two bytes
        CPOL = 1; CPHA = 0; transaction_length = 2'd1; tx_data = 32'h0000CAFE;
        exp_q.push_back(32'h0000BEEF); rxv_cnt = 0;
        spi_xfer(1, 0, 16, 16, 32'hBEEF, 1, -1, m);
        wait_clk(10);
        check("m2_miso_word", m[15:0], 16'hCAFE);
        check("m2_rx_valid_cnt", rxv_cnt, 1);

        // abort after 13 of 32 bits, rx_data must keep the previous word
        CPOL = 0; CPHA = 0; transaction_length = 2'd3; tx_data = 32'h0;
        exp_q.push_back(32'h11223344);
        spi_xfer(0, 0, 32, 32, 32'h11223344, 1, -1, m);
        wait_clk(10);
        tx_data = 32'h89ABCDEF; rxv_cnt = 0; abort_cnt = 0;
        spi_xfer(0, 0, 32, 13, 32'hAAAAAAAA, 1, -1, m);
        wait_clk(10);
        check("abort_pulses", abort_cnt, 1);
        check("abort_rx_valid_cnt", rxv_cnt, 0);
        check("abort_rx_data", rx_data, 32'h11223344);
        check("abort_miso_idle", MISO, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_miso_bits", m[12:0], 13'h1135);

        // overrun with tx_data/CPOL toggled mid-frame
        CPOL = 0; CPHA = 0; transaction_length = 2'd0; tx_data = 32'h0000005B;
        exp_q.push_back(32'h000000C3); rxv_cnt = 0;
        spi_xfer(0, 0, 16, 16, 32'hC396, 1, 4, m);
        wait_clk(10);
        check("ovr_miso_word", m[15:0], 16'h5BFF);
        check("ovr_rx_valid_cnt", rxv_cnt, 1);
        CPOL = 0;

        // reset during bit 5 of a 32-bit frame
        transaction_length = 2'd3; tx_data = 32'hF0F0F0F0;
        spi_xfer(0, 0, 32, 5, 32'h55555555, 0, -1, m);
        rst = 1'b0;
        wait_clk(2);
        check("rst_rx_data", rx_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_miso_idle", MISO, 1'b1);
        CS = 1'b1;
        wait_clk(4);
        rst = 1'b1;
        wait_clk(10);
        transaction_length = 2'd0; tx_data = 32'h00000081;
        exp_q.push_back(32'h00000081); rxv_cnt = 0;
        spi_xfer(0, 0, 8, 8, 32'h81, 1, -1, m);
        wait_clk(10);
        check("post_rst_miso_bits", m[7:0], 8'h81);
        check("post_rst_rx_valid_cnt", rxv_cnt, 1);
        check("post_rst_busy", busy, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
